// File: rtl/sobel_pkg.sv
// Shared definitions for the 3x3 Sobel window generator.
//   DefaultDwidth : default grayscale pixel width
//   Tap*          : window slice indices, tap = 3*row_offset + col_offset
//   BorderMode    : out-of-frame neighbour policy, fixed at build time by the
//                   SOBEL_WINDOW_REPLICATE_EN macro (undefined: zero fill,
//                   defined: replicate nearest in-frame pixel)
package sobel_pkg;

  localparam int unsigned DefaultDwidth = 8;

  localparam int unsigned TapNW = 0;
  localparam int unsigned TapN  = 1;
  localparam int unsigned TapNE = 2;
  localparam int unsigned TapW  = 3;
  localparam int unsigned TapC  = 4;
  localparam int unsigned TapE  = 5;
  localparam int unsigned TapSW = 6;
  localparam int unsigned TapS  = 7;
  localparam int unsigned TapSE = 8;

  typedef enum logic {
    BorderZero,
    BorderReplicate
  } border_mode_e;

`ifdef SOBEL_WINDOW_REPLICATE_EN
  localparam border_mode_e BorderMode = BorderReplicate;
`else
  localparam border_mode_e BorderMode = BorderZero;
`endif

  function automatic int unsigned tap_idx(input int unsigned row, input int unsigned col);
    return 3 * row + col;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Line buffer holding the two previous image rows, one entry per column.
//   clock   : rising-edge clock
//   addr    : column address shared by read and write
//   wr_en   : write wr_data at addr on the next rising edge
//   wr_data : {row r-1, row r} to store for the column
//   rd_data : {row r-2, row r-1} currently stored for the column
// The read is combinational, so a read and a write of the same address in one
// cycle returns the old contents. The storage is never cleared; the consumer
// masks rows that are not yet valid.
module sobel_line_buffer #(
  parameter int unsigned DEPTH  = 720,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator between two first-word-fall-through FIFOs.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   in_dout      : upstream FIFO head pixel, valid while in_empty = 0
//   in_empty     : upstream FIFO empty
//   in_rd_en     : pop upstream FIFO
//   out_din      : 3x3 window, slice [DWIDTH*(3*i+j) +: DWIDTH] = pixel (r-1+i, c-1+j)
//   out_full     : downstream FIFO full
//   out_wr_en    : push out_din downstream
//   frame_done   : pulses with the write of the last window of a frame
// Border mode (zero fill or replicate) is selected by SOBEL_WINDOW_REPLICATE_EN.
// The block walks a (IMG_HEIGHT+1) x (IMG_WIDTH+1) step grid; the extra row and
// column are pad steps that flush the last windows without consuming input.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned DWIDTH     = DefaultDwidth
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DWIDTH-1:0]   in_dout,
  input  logic                in_empty,
  output logic                in_rd_en,
  output logic [9*DWIDTH-1:0] out_din,
  input  logic                out_full,
  output logic                out_wr_en,
  output logic                frame_done
);

  localparam int unsigned ColW  = $clog2(IMG_WIDTH + 1);
  localparam int unsigned RowW  = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned AddrW = $clog2(IMG_WIDTH);
  localparam logic [ColW-1:0] PadCol = ColW'(IMG_WIDTH);
  localparam logic [RowW-1:0] PadRow = RowW'(IMG_HEIGHT);
  localparam bit Replicate = (BorderMode == BorderReplicate);

  logic [ColW-1:0] vc_q, vc_d;
  logic [RowW-1:0] vr_q, vr_d;
  // Window columns c-2 and c-1 relative to the current step; index = row offset.
  logic [2:0][DWIDTH-1:0] col_a_q, col_a_d, col_b_q, col_b_d, col_n;
  logic [9*DWIDTH-1:0] win_q, win_d;
  logic win_valid_q, win_valid_d;
  logic win_last_q, win_last_d;

  logic pad_col, pad_row, pad, step;
  logic [AddrW-1:0] lb_addr;
  logic [2*DWIDTH-1:0] lb_rd, lb_wr;
  logic [DWIDTH-1:0] lb_r1, lb_r2;

  assign pad_col    = (vc_q == PadCol);
  assign pad_row    = (vr_q == PadRow);
  assign pad        = pad_col | pad_row;
  assign step       = (pad | ~in_empty) & (~win_valid_q | ~out_full);
  assign in_rd_en   = step & ~pad & ~reset;
  assign out_wr_en  = win_valid_q & ~out_full;
  assign frame_done = out_wr_en & win_last_q;
  assign out_din    = win_q;

  assign lb_addr = pad_col ? '0 : vc_q[AddrW-1:0];
  assign lb_r1   = lb_rd[DWIDTH-1:0];
  assign lb_r2   = lb_rd[2*DWIDTH-1:DWIDTH];
  assign lb_wr   = {lb_r1, in_dout};

  sobel_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .WIDTH  (2 * DWIDTH),
    .ADDR_W (AddrW)
  ) u_line_buffer (
    .clock   (clock),
    .addr    (lb_addr),
    .wr_en   (step & ~pad),
    .wr_data (lb_wr),
    .rd_data (lb_rd)
  );

  // New rightmost column: rows vr-2, vr-1, vr at column vc. Rows the buffer
  // has not yet written this frame are masked, so stale data never leaks.
  always_comb begin
    col_n    = '0;
    col_n[1] = (vr_q != '0) ? lb_r1 : '0;
    if (vr_q >= RowW'(2)) begin
      col_n[0] = lb_r2;
    end else if (Replicate) begin
      col_n[0] = col_n[1];
    end
    if (!pad_row) begin
      col_n[2] = in_dout;
    end else if (Replicate) begin
      col_n[2] = col_n[1];
    end
    if (pad_col) begin
      col_n = Replicate ? col_b_q : '0;
    end
  end

  always_comb begin
    vc_d        = vc_q;
    vr_d        = vr_q;
    col_a_d     = col_a_q;
    col_b_d     = col_b_q;
    win_d       = win_q;
    win_last_d  = win_last_q;
    win_valid_d = win_valid_q & ~out_wr_en;
    if (step) begin
      // Column -1 of each row is zero or a copy of column 0.
      col_a_d = (vc_q == '0) ? (Replicate ? col_n : '0) : col_b_q;
      col_b_d = col_n;
      if (vr_q != '0 && vc_q != '0) begin
        for (int unsigned i = 0; i < 3; i++) begin
          win_d[DWIDTH*tap_idx(i, 0) +: DWIDTH] = col_a_q[i];
          win_d[DWIDTH*tap_idx(i, 1) +: DWIDTH] = col_b_q[i];
          win_d[DWIDTH*tap_idx(i, 2) +: DWIDTH] = col_n[i];
        end
        win_valid_d = 1'b1;
        win_last_d  = pad_row & pad_col;
      end
      if (pad_col) begin
        vc_d = '0;
        vr_d = pad_row ? '0 : vr_q + RowW'(1);
      end else begin
        vc_d = vc_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vc_q        <= '0;
      vr_q        <= '0;
      col_a_q     <= '0;
      col_b_q     <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      vc_q        <= vc_d;
      vr_q        <= vr_d;
      col_a_q     <= col_a_d;
      col_b_q     <= col_b_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 720: pixels per row, SHALL be >= 2.
REQ-002 Parameter IMG_HEIGHT, default 540: rows per frame, SHALL be >= 2.
REQ-003 Parameter DWIDTH, default 8: bits per grayscale pixel.
REQ-004 Design has one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 in_dout  input  DWIDTH  head word of upstream first-word-fall-through FIFO, valid when in_empty=0.
REQ-008 in_empty  input  1  upstream FIFO empty.
REQ-009 in_rd_en  output  1  pops upstream FIFO this cycle.
REQ-010 out_din  output  9*DWIDTH  3x3 window; slice [DWIDTH*(3*i+j) +: DWIDTH] = pixel (r-1+i, c-1+j), i,j in 0..2, for center (r,c).
REQ-011 out_full  input  1  downstream FIFO full.
REQ-012 out_wr_en  output  1  pushes out_din downstream this cycle.
REQ-013 frame_done  output  1  one-cycle pulse in the cycle the window for center (IMG_HEIGHT-1, IMG_WIDTH-1) is written.

Function
REQ-014 Block SHALL accept exactly IMG_WIDTH*IMG_HEIGHT pixels per frame in raster order and emit exactly IMG_WIDTH*IMG_HEIGHT windows in raster order of center.
REQ-015 Block SHALL walk a virtual grid of (IMG_HEIGHT+1) x (IMG_WIDTH+1) steps (vr, vc); positions with vr=IMG_HEIGHT or vc=IMG_WIDTH are pad steps needing no input pixel.
REQ-016 A step SHALL advance when (pad step or in_empty=0) and (win_valid=0 or out_full=0).
REQ-017 in_rd_en SHALL equal step-advance AND non-pad step; it SHALL never assert while in_empty=1.
REQ-018 Step (vr, vc) with vr>=1 and vc>=1 SHALL load the window for center (vr-1, vc-1) into an output register and set win_valid the next cycle (latency 1 cycle after consuming pixel (r+1,c+1), or after the corresponding pad step).
REQ-019 out_wr_en SHALL equal win_valid AND NOT out_full; win_valid clears on write unless reloaded in the same cycle.
REQ-020 While out_full=1 with win_valid=1, out_din SHALL hold stable and no input SHALL be consumed.
REQ-021 Neighbours outside the frame (row -1, row IMG_HEIGHT, col -1, col IMG_WIDTH) SHALL be 0 (see REQ-026).
REQ-022 After the final step, counters SHALL wrap to (0,0) and the next frame SHALL start with no idle cycle; stale line-buffer contents SHALL never appear in any window.

Reset
REQ-023 On reset: in_rd_en=0, out_wr_en=0, frame_done=0, out_din=0, win_valid=0, step counters=(0,0); effective immediately, no clock required.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first pixel consumed after release is pixel (0,0) of a new frame. Line-buffer RAM need not be cleared.

Configuration
REQ-025 Macro SOBEL_WINDOW_REPLICATE_EN selects border mode.
REQ-026 Undefined: out-of-frame neighbours are 0. Defined: out-of-frame neighbours take the value of the nearest in-frame pixel (row and column clamped independently).

Structure
REQ-027 Package sobel_pkg SHALL hold the default DWIDTH, window tap-index constants (3*i+j), and the border-mode localparam derived from the macro.
REQ-028 Sub-module sobel_line_buffer: IMG_WIDTH-deep, 2*DWIDTH-wide, one read plus one write per cycle at the same address, holding rows r-1 and r-2; one instance.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel(r,c)=10*r+c+1 unless stated)
REQ-029 Free-flowing input and output -> 12 windows; center (1,1) = {1,2,3,11,12,13,21,22,23}; center (0,0) = {0,0,0,0,1,2,0,11,12}; frame_done pulses once.
REQ-030 SOBEL_WINDOW_REPLICATE_EN defined, same stimulus -> center (0,0) = {1,1,2,1,1,2,11,11,12}; center (2,3) = {13,14,14,23,24,24,23,24,24}.
REQ-031 out_full held 1 for 5 cycles after third window valid -> out_din stable, in_rd_en=0 throughout, sequence identical to REQ-029.
REQ-032 in_empty toggled every other cycle -> window sequence identical to REQ-029; in_rd_en never high while in_empty=1.
REQ-033 reset pulsed after 6 pixels consumed -> outputs 0 asynchronously; next full frame reproduces REQ-029 exactly.
REQ-034 Two frames back-to-back, second frame pixel=100+10*r+c -> 24 windows, frame_done pulses twice, no first-frame value in any second-frame window.
